ahb_lite_sram_responder: RTL and testbench

AHB-Lite slave backed by an on-chip word array, with programmable wait states and an ERROR response for illegal accesses. It is the responder end of the bus driven by `ahb_lite_rw_master` and a drop-in alternative to `ahb_lite_sdram`. It lets the master's write/read-compare traffic, byte lanes and error handling be exercised without the SDRAM model and its init/refresh delays.

---
 rtl/ahb_lite_sram_responder.sv | 159 +++++++++++++++
 tb/tb_ahb_lite_sram_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_responder.sv
// rtl/ahb_lite_sram_responder.sv - AHB-Lite slave over an on-chip word array with wait states and ERROR responses
module ahb_lite_sram_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);
  localparam logic [3:0]  WS          = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_READY,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dp_valid_q, dp_valid_d;
  logic             dp_write_q, dp_write_d;
  logic [IDX_W-1:0] dp_idx_q, dp_idx_d;
  logic [3:0]       dp_be_q, dp_be_d;

  logic [31:0]      mem [MEM_WORDS];

  logic [31:0]      word_addr;
  logic             in_range;
  logic             aligned;
  logic             legal;
  logic [3:0]       be;
  logic             complete;

  // Bursts carry per-beat addresses and BUSY/IDLE only differ in HTRANS[0]
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  // Legality check and little-endian byte-lane enables for the address-phase beat
  always_comb begin
    word_addr = {2'b00, HADDR[31:2]};
    in_range  = (word_addr < MEM_WORDS_U);
    aligned   = 1'b1;
    be        = 4'b1111;
    case (HSIZE)
      3'd0: be = 4'b0001 << HADDR[1:0];
      3'd1: begin
        aligned = ~HADDR[0];
        be      = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: aligned = (HADDR[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal = aligned && in_range;
  end

  // Data phase completes OKAY in READY/DONE while a legal beat is outstanding
  assign complete = dp_valid_q && ((state_q == S_READY) || (state_q == S_DONE));

  // Next-state logic; HREADY/HRESP are pure decodes of the registered state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_be_d    = dp_be_q;
    HREADY     = 1'b1;
    HRESP      = 1'b0;

    case (state_q)
      S_WAIT: HREADY = 1'b0;
      S_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase

    if (HREADY) begin
      // READY, DONE and ERR2 all accept the next address phase
      state_d    = S_READY;
      cnt_d      = 4'd0;
      dp_valid_d = 1'b0;
      if (HSEL && HTRANS[1]) begin
        if (!legal) begin
          state_d = S_ERR1;
        end else begin
          dp_valid_d = 1'b1;
          dp_write_d = HWRITE;
          dp_idx_d   = HADDR[IDX_W+1:2];
          dp_be_d    = be;
          if (WS != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end
      end
    end else begin
      case (state_q)
        S_WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = S_DONE;
        end
        S_ERR1:  state_d = S_ERR2;
        default: state_d = S_READY;
      endcase
    end
  end

  // State and data-phase registers; reset drops any outstanding beat
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_READY;
      cnt_q      <= 4'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_be_q    <= 4'b0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      dp_be_q    <= dp_be_d;
    end
  end

  // Commit enabled byte lanes at the edge ending a completing write data phase
  always_ff @(posedge HCLK) begin
    if (!HRESET && complete && dp_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_be_q[i]) mem[dp_idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Whole stored word is driven only during a completing read data phase
  always_comb begin
    HRDATA = 32'h0;
    if (complete && !dp_write_q) HRDATA = mem[dp_idx_q];
  end

endmodule

// File: tb/tb_ahb_lite_sram_responder.sv
// tb/tb_ahb_lite_sram_responder.sv - scoreboard bench for ahb_lite_sram_responder at three wait-state settings
module tb_ahb_lite_sram_responder;

  localparam int         MEM_WORDS = 64;
  localparam int         NDUT      = 3;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] BUSY      = 2'd1;
  localparam logic [1:0] NONSEQ    = 2'd2;
  localparam logic [1:0] SEQ       = 2'd3;
  localparam logic [2:0] B8        = 3'd0;
  localparam logic [2:0] B16       = 3'd1;
  localparam logic [2:0] B32       = 3'd2;
  localparam logic [2:0] SINGLE    = 3'd0;
  localparam logic [2:0] WRAP4     = 3'd2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  waits;
    logic [15:0] id;
  } exp_t;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        hreset [NDUT];
  logic [31:0] haddr  [NDUT];
  logic [2:0]  hburst [NDUT];
  logic        hsel   [NDUT];
  logic [2:0]  hsize  [NDUT];
  logic [1:0]  htrans [NDUT];
  logic [31:0] hwdata [NDUT];
  logic        hwrite [NDUT];
  logic [31:0] hrdata [NDUT];
  logic        hready [NDUT];
  logic        hresp  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ahb_lite_sram_responder #(
      .MEM_WORDS  (MEM_WORDS),
      .WAIT_STATES(ws_of(g))
    ) u_dut (
      .HCLK  (HCLK),
      .HRESET(hreset[g]),
      .HADDR (haddr[g]),
      .HBURST(hburst[g]),
      .HSEL  (hsel[g]),
      .HSIZE (hsize[g]),
      .HTRANS(htrans[g]),
      .HWDATA(hwdata[g]),
      .HWRITE(hwrite[g]),
      .HRDATA(hrdata[g]),
      .HREADY(hready[g]),
      .HRESP (hresp[g])
    );
  end

  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        sb [NDUT][$];
  exp_t        mon_e;
  logic        active     [NDUT] = '{default: 1'b0};
  int          waits      [NDUT] = '{default: 0};
  logic        stall_resp [NDUT] = '{default: 1'b0};
  logic        stall_nz   [NDUT] = '{default: 1'b0};
  logic        post_rst   [NDUT] = '{default: 1'b0};
  logic [31:0] nxt_wdata  [NDUT];
  logic        fin      = 1'b0;
  logic        fin_seen = 1'b0;
  int          beat_id  = 0;

  // Monitor: tracks each DUT's data phase and checks completions against the scoreboard
  always @(negedge HCLK) begin
    for (int d = 0; d < NDUT; d++) begin
      if (hreset[d] === 1'b1) begin
        if (active[d] && sb[d].size() > 0) mon_e = sb[d].pop_front();
        active[d]   = 1'b0;
        post_rst[d] = 1'b1;
      end else begin
        if (post_rst[d]) begin
          n_vec++;
          if (hready[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0) begin
            n_bad++;
            $display("FAIL dut%0d after_reset: got HREADY=%b HRESP=%b HRDATA=%h, need 1 0 00000000",
                     d, hready[d], hresp[d], hrdata[d]);
          end
          post_rst[d] = 1'b0;
        end
        if (active[d]) begin
          if (hready[d] !== 1'b1) begin
            waits[d]++;
            if (hresp[d] === 1'b1) stall_resp[d] = 1'b1;
            if (hrdata[d] !== 32'h0) stall_nz[d] = 1'b1;
          end else begin
            n_vec++;
            if (sb[d].size() == 0) begin
              n_bad++;
              $display("FAIL dut%0d unexpected_completion: got HRESP=%b HRDATA=%h, need no pending beat",
                       d, hresp[d], hrdata[d]);
            end else begin
              mon_e = sb[d].pop_front();
              if (hrdata[d] !== mon_e.rdata || hresp[d] !== mon_e.err || waits[d] != int'(mon_e.waits) ||
                  stall_resp[d] !== mon_e.err || stall_nz[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL dut%0d beat%0d: got HRDATA=%h HRESP=%b waits=%0d stall_HRESP=%b stall_HRDATA_nonzero=%b, need HRDATA=%h HRESP=%b waits=%0d stall_HRESP=%b stall_HRDATA_nonzero=0",
                         d, mon_e.id, hrdata[d], hresp[d], waits[d], stall_resp[d], stall_nz[d],
                         mon_e.rdata, mon_e.err, mon_e.waits, mon_e.err);
              end
            end
            active[d] = 1'b0;
          end
        end
        if (hready[d] === 1'b1 && hsel[d] === 1'b1 && htrans[d][1] === 1'b1) begin
          active[d]     = 1'b1;
          waits[d]      = 0;
          stall_resp[d] = 1'b0;
          stall_nz[d]   = 1'b0;
        end
      end
    end
    if (fin && !fin_seen) begin
      for (int d = 0; d < NDUT; d++) begin
        n_vec++;
        if (sb[d].size() != 0 || active[d]) begin
          n_bad++;
          $display("FAIL dut%0d drain: got %0d beats pending (active=%b), need 0", d, sb[d].size(), active[d]);
        end
      end
      fin_seen = 1'b1;
    end
  end

  task automatic wait_accept(input int d);
    int n;
    n = 0;
    @(negedge HCLK);
    while (hready[d] !== 1'b1) begin
      n++;
      if (n > 40) begin
        $display("FAIL dut%0d accept_timeout: got HREADY=%b for 40 cycles, need 1", d, hready[d]);
        $fatal(1, "bus hang");
      end
      @(negedge HCLK);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic issue(input int d, input logic sel, input logic [1:0] trans, input logic [2:0] burst,
                       input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    hsel[d]   = sel;
    htrans[d] = trans;
    hburst[d] = burst;
    hwrite[d] = wr;
    hsize[d]  = sz;
    haddr[d]  = addr;
    hwdata[d] = nxt_wdata[d];
    if (sel && trans[1]) begin
      e.rdata = (wr || exp_err) ? 32'h0 : exp_rd;
      e.err   = exp_err;
      e.waits = 8'(exp_err ? 1 : ws_of(d));
      e.id    = 16'(beat_id);
      beat_id++;
      sb[d].push_back(e);
    end
    wait_accept(d);
    nxt_wdata[d] = wr ? wd : 32'h0;
  endtask

  task automatic wr(input int d, input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] data,
                    input logic err);
    issue(d, 1'b1, NONSEQ, SINGLE, 1'b1, sz, addr, data, 32'h0, err);
  endtask

  task automatic rd(input int d, input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] exp_rd,
                    input logic err);
    issue(d, 1'b1, NONSEQ, SINGLE, 1'b0, sz, addr, 32'h0, exp_rd, err);
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) issue(d, 1'b1, IDLE, SINGLE, 1'b0, B32, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Stimulus: directed beats per DUT, expected responses pushed as they are issued
  initial begin
    logic [31:0] a;
    for (int d = 0; d < NDUT; d++) begin
      hreset[d]    = 1'b1;
      haddr[d]     = 32'h0;
      hburst[d]    = SINGLE;
      hsel[d]      = 1'b0;
      hsize[d]     = B32;
      htrans[d]    = IDLE;
      hwdata[d]    = 32'h0;
      hwrite[d]    = 1'b0;
      nxt_wdata[d] = 32'h0;
    end
    repeat (3) @(posedge HCLK);
    #1;
    for (int d = 0; d < NDUT; d++) hreset[d] = 1'b0;

    // zero wait states: word write/read, back-to-back same address
    wr(0, B32, 32'h10, 32'hDEADBEEF, 1'b0);
    rd(0, B32, 32'h10, 32'hDEADBEEF, 1'b0);
    idle(0, 1);
    wr(0, B32, 32'h00, 32'h0000C0DE, 1'b0);
    rd(0, B32, 32'h10, 32'hDEADBEEF, 1'b0);
    // byte and halfword lanes
    wr(0, B32, 32'h20, 32'h00000000, 1'b0);
    wr(0, B8,  32'h21, 32'h1234AA56, 1'b0);
    wr(0, B16, 32'h22, 32'h5555BEEF, 1'b0);
    rd(0, B32, 32'h20, 32'h5555AA00, 1'b0);
    wr(0, B16, 32'h20, 32'hFFFF1234, 1'b0);
    wr(0, B8,  32'h23, 32'h77FFFFFF, 1'b0);
    rd(0, B8,  32'h23, 32'h77551234, 1'b0);
    rd(0, B16, 32'h22, 32'h77551234, 1'b0);
    // BUSY and deselected beats must not write
    issue(0, 1'b1, BUSY,   SINGLE, 1'b1, B32, 32'h10, 32'h0BADF00D, 32'h0, 1'b0);
    issue(0, 1'b0, NONSEQ, SINGLE, 1'b1, B32, 32'h10, 32'h0BADF00D, 32'h0, 1'b0);
    rd(0, B32, 32'h10, 32'hDEADBEEF, 1'b0);
    // errors, including back-to-back errors and a legal beat taken in ERR2
    wr(0, B32, 32'hFC, 32'hCAFEF00D, 1'b0);
    rd(0, B32, 32'h02, 32'h0, 1'b1);
    rd(0, B32, 32'h10, 32'hDEADBEEF, 1'b0);
    wr(0, B32, 32'h12, 32'hBAD0BAD0, 1'b1);
    wr(0, B16, 32'h11, 32'hBAD0BAD0, 1'b1);
    wr(0, 3'd3, 32'h10, 32'hBAD0BAD0, 1'b1);
    wr(0, B32, 32'(MEM_WORDS * 4), 32'hBAD0BAD0, 1'b1);
    rd(0, B32, 32'hFC, 32'hCAFEF00D, 1'b0);
    rd(0, B32, 32'h10, 32'hDEADBEEF, 1'b0);
    rd(0, B32, 32'h00, 32'h0000C0DE, 1'b0);
    idle(0, 2);

    // three wait states: WRAP4 write then WRAP4 read starting mid-wrap
    for (int i = 0; i < 4; i++) begin
      a = 32'h30 + 32'(4 * i);
      issue(1, 1'b1, (i == 0) ? NONSEQ : SEQ, WRAP4, 1'b1, B32, a, 32'hA0000000 | a, 32'h0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'h30 + ((32'h8 + 32'(4 * i)) & 32'hF);
      issue(1, 1'b1, (i == 0) ? NONSEQ : SEQ, WRAP4, 1'b0, B32, a, 32'h0, 32'hA0000000 | a, 1'b0);
    end
    rd(1, B32, 32'h31, 32'h0, 1'b1);
    rd(1, B32, 32'h30, 32'hA0000030, 1'b0);
    idle(1, 2);

    // two wait states: reset in the middle of a write's wait phase
    wr(2, B32, 32'h40, 32'h11111111, 1'b0);
    rd(2, B32, 32'h40, 32'h11111111, 1'b0);
    idle(2, 1);
    wr(2, B32, 32'h40, 32'h99999999, 1'b0);
    hreset[2] = 1'b1;
    htrans[2] = IDLE;
    hwdata[2] = 32'h99999999;
    @(posedge HCLK);
    #1;
    hreset[2] = 1'b0;
    idle(2, 2);
    rd(2, B32, 32'h40, 32'h11111111, 1'b0);
    idle(2, 2);

    fin = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
